// File: rtl/sonar_audio_pkg.sv
// Shared constants and types for the sonar audio path: CIC accumulator width,
// PCM sample type and its saturation limits.
package sonar_audio_pkg;

  localparam int ACC_W = 26;
  localparam int OUT_W = 16;

  typedef logic signed [OUT_W-1:0] pcm_t;

  localparam pcm_t PCM_MAX = 16'sh7FFF;
  localparam pcm_t PCM_MIN = 16'sh8000;

endpackage

// File: rtl/pdm_clkgen.sv
// PDM bit-clock divider, input synchronizer and sample-tick generation.
// The data bit is taken at the end of the clock high phase.
module pdm_clkgen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic en,
  input  logic pdw_data,
  output logic pdw_clk,
  output logic s_tick,
  output logic s_bit
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          pdw_clk_q, pdw_clk_d;
  logic [1:0]    sync_q, sync_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!en) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == CW'(CLK_DIV - 1)) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
    // Clock register tracks the next count so it is aligned with div_cnt_q.
    pdw_clk_d = en && (div_cnt_d >= CW'(CLK_DIV / 2));
    sync_d    = {sync_q[0], pdw_data};
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pdw_clk_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdw_clk_q <= pdw_clk_d;
      sync_q    <= sync_d;
    end
  end

  assign pdw_clk = pdw_clk_q;
  assign s_tick  = en && (div_cnt_q == CW'(CLK_DIV - 1));
  assign s_bit   = sync_q[1];

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: 4th-order CIC decimator (R = 2^DECIM_LOG2) producing
// signed PCM samples with a one-cycle valid strobe after a 4-result warm-up.
module pdm_mic_rx #(
  parameter int CLK_DIV    = 16,
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 16
) (
  input  logic                    clk48,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    pdw_clk,
  input  logic                    pdw_data,
  output logic signed [OUT_W-1:0] pcm_data,
  output logic                    pcm_valid
);

  import sonar_audio_pkg::*;

  localparam int AW = 2 + 4 * DECIM_LOG2;

  typedef logic signed [AW-1:0] acc_t;

  function automatic logic signed [OUT_W-1:0] scale_sat(input acc_t v);
    if (!v[AW-1] && v[AW-2]) begin
      return PCM_MAX;
    end else if (v[AW-1] && !v[AW-2]) begin
      return PCM_MIN;
    end else begin
      return v[AW-2 -: OUT_W];
    end
  endfunction

  logic s_tick, s_bit, d_tick;
  acc_t x;

  acc_t                    integ_q [4];
  acc_t                    integ_d [4];
  acc_t                    comb_q  [4];
  acc_t                    comb_d  [4];
  acc_t                    dly_q   [4];
  acc_t                    dly_d   [4];
  logic [DECIM_LOG2-1:0]   dec_cnt_q, dec_cnt_d;
  logic                    primed_q, primed_d;
  logic [3:0]              stg_q, stg_d;
  logic [2:0]              warm_q, warm_d;
  logic signed [OUT_W-1:0] pcm_q, pcm_d;
  logic                    pcm_valid_q, pcm_valid_d;

  pdm_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk48    (clk48),
    .rst_n    (rst_n),
    .en       (en),
    .pdw_data (pdw_data),
    .pdw_clk  (pdw_clk),
    .s_tick   (s_tick),
    .s_bit    (s_bit)
  );

  always_comb begin
    x           = s_bit ? acc_t'(1) : acc_t'(-1);
    d_tick      = 1'b0;
    dec_cnt_d   = dec_cnt_q;
    primed_d    = primed_q;
    stg_d       = stg_q;
    warm_d      = warm_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      integ_d[k] = integ_q[k];
      comb_d[k]  = comb_q[k];
      dly_d[k]   = dly_q[k];
    end

    if (!en) begin
      dec_cnt_d = '0;
      primed_d  = 1'b0;
      stg_d     = '0;
      warm_d    = '0;
      for (int k = 0; k < 4; k++) begin
        integ_d[k] = '0;
        comb_d[k]  = '0;
        dly_d[k]   = '0;
      end
    end else begin
      // Integrator stage: full input rate, modulo-2^AW wrap is intended.
      if (s_tick) begin
        integ_d[0] = integ_q[0] + x;
        for (int k = 1; k < 4; k++) begin
          integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        dec_cnt_d = dec_cnt_q + DECIM_LOG2'(1);
        if (dec_cnt_q == '1) begin
          primed_d = 1'b1;
        end
        d_tick = primed_q && (dec_cnt_q == '0);
      end

      // Comb stages: one differentiator per cycle after the decimation tick.
      stg_d = {stg_q[2:0], d_tick};
      if (d_tick) begin
        dly_d[0]  = integ_q[3];
        comb_d[0] = integ_q[3] - dly_q[0];
      end
      for (int k = 1; k < 4; k++) begin
        if (stg_q[k-1]) begin
          dly_d[k]  = comb_q[k-1];
          comb_d[k] = comb_q[k-1] - dly_q[k];
        end
      end

      // Output stage: results during warm-up only fill the comb delays.
      if (stg_q[3]) begin
        if (warm_q == 3'd4) begin
          pcm_valid_d = 1'b1;
          pcm_d       = scale_sat(comb_q[3]);
        end else begin
          warm_d = warm_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q   <= '0;
      primed_q    <= 1'b0;
      stg_q       <= '0;
      warm_q      <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        integ_q[k] <= '0;
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
      end
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      primed_q    <= primed_d;
      stg_q       <= stg_d;
      warm_q      <= warm_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      for (int k = 0; k < 4; k++) begin
        integ_q[k] <= integ_d[k];
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
      end
    end
  end

  assign pcm_data  = pcm_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Scoreboard bench for pdm_mic_rx: directed PDM patterns, enable and reset
// disturbances, expected PCM strobes queued with value, tolerance and cycle.
`timescale 1ns/1ps
module tb_pdm_mic_rx;

  localparam int FIRST_LAT = 5 * 1024 + 16 + 4;
  localparam int SPACING   = 1024;

  typedef struct {
    int val;
    int tol;
    int at;
  } exp_t;

  logic               clk48 = 1'b0;
  logic               rst_n = 1'b0;
  logic               en    = 1'b0;
  logic               pdw_clk;
  logic               pdw_data;
  logic signed [15:0] pcm_data;
  logic               pcm_valid;

  logic [3:0] pat = 4'hF;
  logic [1:0] ph  = 2'd0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  assign pdw_data = pat[ph];

  pdm_mic_rx #(
    .CLK_DIV    (16),
    .DECIM_LOG2 (6),
    .OUT_W      (16)
  ) dut (
    .clk48     (clk48),
    .rst_n     (rst_n),
    .en        (en),
    .pdw_clk   (pdw_clk),
    .pdw_data  (pdw_data),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid)
  );

  always #10 clk48 = ~clk48;

  always @(posedge clk48) cyc <= cyc + 1;

  // Microphone model: next pattern bit presented on each falling bit clock.
  always @(negedge pdw_clk) ph <= ph + 2'd1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk48);
  endtask

  task automatic push_exp(input int val, input int tol, input int at, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.val = val;
      e.tol = tol;
      e.at  = at + i * SPACING;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk48);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cyc=%0d pending=%0d expected=0", cyc, sb.size());
      sb.delete();
    end
    tick(2);
  endtask

  task automatic reset_and_release(output int rel);
    @(negedge clk48);
    rst_n = 1'b0;
    tick(3);
    check("rst_pdw_clk", int'(pdw_clk), 0);
    check("rst_pcm_valid", int'(pcm_valid), 0);
    check("rst_pcm_data", int'(pcm_data), 0);
    rst_n = 1'b1;
    rel = cyc;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk48);
      if (pcm_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid cyc=%0d pcm_data=%0d expected no strobe", cyc, pcm_data);
        end else begin
          e = sb.pop_front();
          d = int'(pcm_data) - e.val;
          if (d < 0) d = -d;
          checks++;
          if (d > e.tol) begin
            errors++;
            $display("FAIL pcm_value cyc=%0d got=%0d expected=%0d tol=%0d", cyc, pcm_data, e.val, e.tol);
          end
          checks++;
          if (cyc != e.at) begin
            errors++;
            $display("FAIL pcm_timing got_cyc=%0d expected_cyc=%0d", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d expected simulation end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int ena;
    int last;

    // All-ones input from reset: bit clock shape, full-scale positive output.
    pat = 4'hF;
    en  = 1'b1;
    tick(4);
    check("por_pdw_clk", int'(pdw_clk), 0);
    check("por_pcm_valid", int'(pcm_valid), 0);
    check("por_pcm_data", int'(pcm_data), 0);
    rst_n = 1'b1;
    rel = cyc;
    push_exp(32767, 0, rel + FIRST_LAT, 3);
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      check("pdw_clk_phase", int'(pdw_clk), ((i % 16) >= 8) ? 1 : 0);
    end
    drain(8000);

    // Enable low for 3000 cycles: clock parked low, data held, no strobes.
    en = 1'b0;
    tick(1);
    for (int i = 0; i < 3000; i++) begin
      if (pdw_clk !== 1'b0) check("en_low_pdw_clk", int'(pdw_clk), 0);
      tick(1);
    end
    check("en_low_clk_final", int'(pdw_clk), 0);
    check("en_low_pcm_hold", int'(pcm_data), 32767);
    en  = 1'b1;
    ena = cyc;
    push_exp(32767, 0, ena + FIRST_LAT, 2);
    drain(8000);

    // Reset between the decimation tick and the last comb stage.
    last = ena + FIRST_LAT + SPACING;
    while (cyc < last + 1021) @(negedge clk48);
    rst_n = 1'b0;
    #1;
    check("midrst_pdw_clk", int'(pdw_clk), 0);
    check("midrst_pcm_valid", int'(pcm_valid), 0);
    check("midrst_pcm_data", int'(pcm_data), 0);
    tick(3);
    check("midrst_hold_data", int'(pcm_data), 0);
    rst_n = 1'b1;
    rel = cyc;
    push_exp(32767, 0, rel + FIRST_LAT, 1);
    drain(7000);

    // All-zeros input: full-scale negative output.
    pat = 4'h0;
    reset_and_release(rel);
    push_exp(-32768, 0, rel + FIRST_LAT, 2);
    drain(8000);

    // Alternating 1010 input: zero mean.
    pat = 4'b0101;
    reset_and_release(rel);
    push_exp(0, 1, rel + FIRST_LAT, 2);
    drain(8000);

    // 1110 repeating: 75 % ones gives half of positive full scale.
    pat = 4'b0111;
    reset_and_release(rel);
    push_exp(16384, 1, rel + FIRST_LAT, 2);
    drain(8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
